// File: rtl/byte_serial_adder_pkg.sv
// Shared types and constants for the byte-serial wide adder.
package byte_serial_adder_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte index width; a single-bit index is kept as the floor so the counter never collapses to zero width.
    function automatic int idx_width(input int num_bytes);
        return (num_bytes > 1) ? $clog2(num_bytes) : 1;
    endfunction

endpackage

// File: rtl/carry_select_adder.sv
// 8-bit carry-select adder: the low nibble ripples, the high nibble is precomputed for both carries.
module carry_select_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;

    always_comb begin
        lo   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
        hi0  = {1'b0, a[7:4]} + {1'b0, b[7:4]};
        hi1  = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
        sum  = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
        cout = lo[4] ? hi1[4] : hi0[4];
    end

endmodule

// File: rtl/byte_serial_wide_adder.sv
// Wide-operand front end: adds two NUM_BYTES-byte operands one byte per cycle, LSB first.
// Optional subtract mode is enabled with `define BYTE_SERIAL_WIDE_ADDER_SUB_EN.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both high;
// in_ready/out_valid never depend combinationally on in_valid/out_ready.
module byte_serial_wide_adder
    import byte_serial_adder_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BYTE_W*NUM_BYTES-1:0] a,
    input  logic [BYTE_W*NUM_BYTES-1:0] b,
    input  logic                        c_in,
`ifdef BYTE_SERIAL_WIDE_ADDER_SUB_EN
    input  logic                        sub,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BYTE_W*NUM_BYTES-1:0] sum,
    output logic                        carry_out,
    output state_t                      state_dbg
);

    localparam int W     = BYTE_W * NUM_BYTES;
    localparam int IDX_W = idx_width(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_t             state_q;
    state_t             state_d;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic               accept;
    logic               last_byte;
    logic               carry_init;
    logic [BYTE_W-1:0]  byte_a;
    logic [BYTE_W-1:0]  byte_b;
    logic [BYTE_W-1:0]  byte_sum;
    logic               byte_cout;

`ifdef BYTE_SERIAL_WIDE_ADDER_SUB_EN
    logic sub_q;

    // Subtraction is a + ~b + 1, so the seed carry replaces c_in.
    assign carry_init = sub ? 1'b1 : c_in;
    assign byte_b     = b_q[int'(idx_q)*BYTE_W +: BYTE_W] ^ {BYTE_W{sub_q}};
`else
    assign carry_init = c_in;
    assign byte_b     = b_q[int'(idx_q)*BYTE_W +: BYTE_W];
`endif

    assign byte_a    = a_q[int'(idx_q)*BYTE_W +: BYTE_W];
    assign accept    = in_valid && in_ready;
    assign last_byte = (idx_q == LAST_IDX);
    assign out_valid = (state_q == DONE);
    assign state_dbg = state_q;

    carry_select_adder u_byte_adder (
        .a    (byte_a),
        .b    (byte_b),
        .cin  (carry_q),
        .sum  (byte_sum),
        .cout (byte_cout)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_byte) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // in_ready is registered so it stays low through reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
`ifdef BYTE_SERIAL_WIDE_ADDER_SUB_EN
            sub_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d == IDLE);
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                carry_q <= carry_init;
                idx_q   <= '0;
`ifdef BYTE_SERIAL_WIDE_ADDER_SUB_EN
                sub_q   <= sub;
`endif
            end
            if (state_q == RUN) begin
                sum[int'(idx_q)*BYTE_W +: BYTE_W] <= byte_sum;
                carry_q <= byte_cout;
                if (last_byte) begin
                    carry_out <= byte_cout;
                    idx_q     <= '0;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_byte_serial_wide_adder.sv
// Self-checking bench for byte_serial_wide_adder: directed cases, reset abort and random operands.
module tb_byte_serial_wide_adder;
    import byte_serial_adder_pkg::*;

    localparam int NB = 4;
    localparam int W  = 8 * NB;
`ifdef BYTE_SERIAL_WIDE_ADDER_SUB_EN
    localparam bit SUB_ON = 1'b1;
`else
    localparam bit SUB_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         carry_out;
    state_t       state_dbg;

    int n_checks = 0;
    int n_fails  = 0;
    logic [W:0] exp_q[$];

    byte_serial_wide_adder #(.NUM_BYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef BYTE_SERIAL_WIDE_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .state_dbg (state_dbg)
    );

    // Clock and time limit
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic; subtract reports "no borrow" as a >= b.
    function automatic logic [W:0] model(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                                         input logic cin, input logic op_sub);
        logic [W-1:0] diff;
        if (op_sub) begin
            diff = op_a - op_b;
            return {(op_a >= op_b), diff};
        end
        return {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, cin};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic cin,
                         input logic op_sub, input int stall);
        int waited;
        logic [W:0] exp;
        waited = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("in_ready_idle", in_ready, 1);
        a = op_a;
        b = op_b;
        c_in = cin;
        sub = op_sub;
        in_valid = 1'b1;
        exp_q.push_back(model(op_a, op_b, cin, SUB_ON && op_sub));
        tick();
        // Scramble the inputs and poke out_ready during RUN; both must be ignored.
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        c_in = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        out_ready = 1'b1;
        check("in_ready_after_accept", in_ready, 0);
        waited = 0;
        while (!out_valid && waited < 20) begin
            tick();
            waited++;
        end
        out_ready = 1'b0;
        check("latency", waited, NB);
        exp = exp_q.pop_front();
        check("sum", sum, exp[W-1:0]);
        check("carry_out", carry_out, exp[W]);
        check("state_done", state_dbg, DONE);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            tick();
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_sum", sum, exp[W-1:0]);
            check("stall_carry", carry_out, exp[W]);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("handoff_out_valid", out_valid, 0);
        check("handoff_in_ready", in_ready, 1);
        check("handoff_state", state_dbg, IDLE);
    endtask

    initial begin
        // Reset held three cycles
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_carry", carry_out, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_state", state_dbg, IDLE);
        rst_n = 1'b1;
        check("release_in_ready_low", in_ready, 0);
        tick();
        check("release_in_ready_high", in_ready, 1);

        // Directed cases
        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
        do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1);
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 5);

        // Reset mid-RUN discards the partial result
        a = 32'hFFFF_FFFF;
        b = 32'h0000_0001;
        c_in = 1'b0;
        sub = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_carry", carry_out, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_state", state_dbg, IDLE);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("abort_no_valid", out_valid, 0);
        end
        do_op(32'd5, 32'd7, 1'b0, 1'b0, 0);

        if (SUB_ON) begin
            do_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1, 0);
            do_op(32'h0000_0020, 32'h0000_0010, 1'b0, 1'b1, 2);
            do_op(32'h0000_0020, 32'h0000_0010, 1'b1, 1'b0, 0);
        end

        // Random operands, carries and stalls
        for (int n = 0; n < 16; n++) begin
            do_op($urandom, $urandom, 1'($urandom_range(0, 1)),
                  SUB_ON & 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
